// File: rtl/eta_pkg.sv
// Shared definitions for the error-tolerant adder recovery path:
// default geometry, segment-count derivation and the recovery FSM states.
package eta_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SEG_DEF   = 4;
    localparam int NSEG_DEF  = WIDTH_DEF / SEG_DEF;

    // Number of segments a WIDTH-bit word splits into at SEG bits each.
    function automatic int nseg_of(input int width, input int seg);
        return width / seg;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORRECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/seg_carry_gen.sv
// Raw per-segment carry generator: rc[k] is the carry-out of segment k added
// in isolation, with cin feeding segment 0 only. Purely combinational.
module seg_carry_gen
    import eta_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEG   = SEG_DEF
) (
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    input  logic                              cin,
    output logic [nseg_of(WIDTH, SEG)-1:0]    rc
);

    localparam int NSEG = nseg_of(WIDTH, SEG);

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic             seg_cin;
        logic [SEG:0]     seg_sum;

        if (k == 0) begin : g_first
            assign seg_cin = cin;
        end else begin : g_rest
            assign seg_cin = 1'b0;
        end

        assign seg_sum = {1'b0, a[k*SEG +: SEG]} + {1'b0, b[k*SEG +: SEG]}
                       + {{SEG{1'b0}}, seg_cin};
        assign rc[k]   = seg_sum[SEG];
    end

endmodule

// File: rtl/eta2_err_recover.sv
// Error-recovery back end for the segmented (carry-cut) adder. Accepts the
// operands and the approximate sum, and if any lower segment dropped a carry,
// re-injects carries one segment per cycle to produce the exact sum.
module eta2_err_recover
    import eta_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEG   = SEG_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     a,
    input  logic [WIDTH-1:0]                     b,
    input  logic                                 cin,
    input  logic [WIDTH-1:0]                     y_apx,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH-1:0]                     y,
    output logic                                 cout,
    output logic                                 err_flag,
    output logic [$clog2(WIDTH/SEG):0]           corr_cycles
);

    localparam int NSEG = nseg_of(WIDTH, SEG);
    localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int CCW  = $clog2(NSEG) + 1;

    if ((WIDTH % SEG) != 0 || NSEG < 2) begin : g_bad_params
        $error("eta2_err_recover: WIDTH must be a multiple of SEG with at least two segments");
    end

    state_t             state;
    logic [WIDTH-1:0]   s;          // working sum, corrected in place
    logic [NSEG-1:0]    rc;         // raw carries from the current inputs
    logic [NSEG-1:0]    rc_q;       // raw carries captured at accept
    logic               rip;        // carry rippling out of the last corrected segment
    logic [IDXW-1:0]    idx;        // segment being corrected
    logic               ci;
    logic [SEG:0]       seg_sum;
    logic [WIDTH-1:0]   s_upd;

    seg_carry_gen #(
        .WIDTH (WIDTH),
        .SEG   (SEG)
    ) u_seg_carry_gen (
        .a   (a),
        .b   (b),
        .cin (cin),
        .rc  (rc)
    );

    assign in_ready = (state == IDLE);

    // Add the incoming carry into segment idx of the working sum.
    always_comb begin
        // NOTE: every output of this block gets a value before any conditional
        // logic, so no path leaves one unassigned and no latch is inferred.
        ci                    = rc_q[idx - 1'b1] | rip;
        seg_sum               = {1'b0, s[idx*SEG +: SEG]} + {{SEG{1'b0}}, ci};
        s_upd                 = s;
        s_upd[idx*SEG +: SEG] = seg_sum[SEG-1:0];
    end

    // Recovery FSM: accept, optionally walk the segments, then hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s           <= '0;
            rc_q        <= '0;
            rip         <= 1'b0;
            idx         <= '0;
            y           <= '0;
            cout        <= 1'b0;
            err_flag    <= 1'b0;
            corr_cycles <= '0;
            out_valid   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register sees the pre-edge values of the others.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s    <= y_apx;
                        rc_q <= rc;
                        rip  <= 1'b0;
                        if (|rc[NSEG-2:0]) begin
                            state <= CORRECT;
                            idx   <= IDXW'(1);
                        end else begin
                            // Only a top-segment carry (or none): approximate sum is exact.
                            state       <= DONE;
                            y           <= y_apx;
                            cout        <= rc[NSEG-1];
                            err_flag    <= 1'b0;
                            corr_cycles <= '0;
                            out_valid   <= 1'b1;
                        end
                    end
                end

                CORRECT: begin
                    s   <= s_upd;
                    rip <= seg_sum[SEG];
                    if (idx == IDXW'(NSEG - 1)) begin
                        state       <= DONE;
                        y           <= s_upd;
                        cout        <= rc_q[NSEG-1] | seg_sum[SEG];
                        err_flag    <= 1'b1;
                        corr_cycles <= CCW'(NSEG - 1);
                        out_valid   <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eta2_err_recover.sv
// Scoreboard bench for eta2_err_recover: a driver pushes expected results
// (computed from plain integer addition) and a monitor pops and compares them
// whenever the DUT presents a result.
module tb_eta2_err_recover;

    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int NSEG  = WIDTH / SEG;
    localparam int CCW   = $clog2(NSEG) + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               cin;
    logic [WIDTH-1:0]   y_apx;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   y;
    logic               cout;
    logic               err_flag;
    logic [CCW-1:0]     corr_cycles;

    eta2_err_recover #(
        .WIDTH (WIDTH),
        .SEG   (SEG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .y_apx       (y_apx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y           (y),
        .cout        (cout),
        .err_flag    (err_flag),
        .corr_cycles (corr_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             cout;
        logic             err;
        logic [CCW-1:0]   cc;
        int               lat;
        int               acc;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got unexpected condition expected none (cycle %0d)", name, cyc);
    endtask

    // Approximate adder: each segment added on its own, carries between segments dropped.
    function automatic logic [WIDTH-1:0] apx_sum(input logic [WIDTH-1:0] av, bv, input logic ci);
        int mask = (1 << SEG) - 1;
        int r = 0;
        for (int k = 0; k < NSEG; k++) begin
            int part = (int'(av >> (k*SEG)) & mask) + (int'(bv >> (k*SEG)) & mask)
                     + ((k == 0) ? int'(ci) : 0);
            r = r | ((part & mask) << (k*SEG));
        end
        return WIDTH'(r);
    endfunction

    // Reference: exact sum is ordinary addition; error if any lower segment overflows.
    function automatic exp_t model(input logic [WIDTH-1:0] av, bv, input logic ci, input int acc);
        exp_t e;
        int   mask = (1 << SEG) - 1;
        int   full = int'(av) + int'(bv) + int'(ci);
        bit   err  = 1'b0;
        for (int k = 0; k < NSEG - 1; k++) begin
            int part = (int'(av >> (k*SEG)) & mask) + (int'(bv >> (k*SEG)) & mask)
                     + ((k == 0) ? int'(ci) : 0);
            if (part > mask) err = 1'b1;
        end
        e.y    = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.err  = err;
        e.cc   = err ? CCW'(NSEG - 1) : '0;
        e.lat  = err ? NSEG : 1;
        e.acc  = acc;
        return e;
    endfunction

    // Offer one transaction; while the DUT is busy, drive junk that must be ignored.
    task automatic send(input logic [WIDTH-1:0] av, bv, input logic ci);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            in_valid = 1'($urandom);
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            cin      = 1'($urandom);
            y_apx    = WIDTH'($urandom);
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            fail_now("in_ready_timeout");
            in_valid = 1'b0;
            return;
        end
        a        = av;
        b        = bv;
        cin      = ci;
        y_apx    = apx_sum(av, bv, ci);
        in_valid = 1'b1;
        q.push_back(model(av, bv, ci, cyc));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        in_valid = 1'b0;
        while ((q.size() != 0 || out_valid) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) fail_now("drain_timeout");
    endtask

    // Monitor: compare each presented result, apply random back-pressure.
    initial begin
        exp_t cur;
        bit   active = 1'b0;
        int   held = 0;
        int   hold_tgt = 0;
        int   ntx = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                active    = 1'b0;
                out_ready = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (!active) begin
                    if (q.size() == 0) begin
                        fail_now("spurious_output");
                    end else begin
                        cur = q.pop_front();
                        check("latency", cyc - cur.acc, cur.lat);
                    end
                    active   = 1'b1;
                    held     = 0;
                    hold_tgt = (ntx == 1) ? 5 : $urandom_range(0, 2);
                    ntx++;
                end
                check("y", y, cur.y);
                check("cout", cout, cur.cout);
                check("err_flag", err_flag, cur.err);
                check("corr_cycles", corr_cycles, cur.cc);
                check("in_ready_busy", in_ready, 0);
                if (held >= hold_tgt) begin
                    out_ready = 1'b1;
                    active    = 1'b0;
                end else begin
                    out_ready = 1'b0;
                    held++;
                end
            end else begin
                out_ready = 1'b0;
                if (active) begin
                    fail_now("valid_dropped");
                    active = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        y_apx    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_cout", cout, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_corr_cycles", corr_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed cases; the second one is held 5 cycles by the monitor.
        send(16'h1234, 16'h4321, 1'b0);
        send(16'h000F, 16'h0001, 1'b0);
        send(16'h0FFF, 16'h0001, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1);
        send(16'h8000, 16'h8000, 1'b0);
        drain();

        // Reset during correction at idx=2 discards the transaction.
        send(16'h00FF, 16'h0F01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y", y, 0);
        check("midrst_cout", cout, 0);
        check("midrst_err_flag", err_flag, 0);
        check("midrst_corr_cycles", corr_cycles, 0);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);

        // Randomized traffic biased toward carry chains.
        for (int n = 0; n < 60; n++) begin
            logic [WIDTH-1:0] av;
            logic [WIDTH-1:0] bv;
            logic             ci;
            av = WIDTH'($urandom);
            bv = WIDTH'($urandom);
            ci = 1'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: bv = ~av;
                2: begin av = av | 16'h0FFF; bv = WIDTH'($urandom_range(0, 3)); end
                default: begin av = 16'hFFFF; bv = WIDTH'($urandom_range(0, 1)); end
            endcase
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send(av, bv, ci);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eta2_err_recover.md
Name: eta2_err_recover

Overview:
Error-recovery back end for the 4-segment error-tolerant adder, which cuts carries between segments.
Consumes the operands plus the approximate sum, detects dropped inter-segment carries, and re-injects them sequentially, one segment per cycle, to produce the exact sum.
Sits downstream of the approximate adder in the accuracy-configurable MAC datapath, behind valid/ready handshakes on both sides.
Error-free operands complete in 1 cycle; erroneous ones take NSEG cycles.

Parameters:
WIDTH, 16, operand/sum width
SEG, 4, segment width; WIDTH % SEG == 0 required
NSEG, WIDTH/SEG, derived localparam (not overridable), number of segments

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream transaction valid
in_ready  output  1  block can accept (state IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to segment 0
y_apx  input  WIDTH  approximate sum from the segmented adder
out_valid  output  1  exact result valid
out_ready  input  1  downstream accepts result
y  output  WIDTH  exact sum
cout  output  1  exact carry-out
err_flag  output  1  approximate sum was wrong, i.e. any lower-segment carry was dropped
corr_cycles  output  $clog2(NSEG)+1  correction cycles spent: 0 or NSEG-1

Behaviour:
- Reset (async, rst_n=0): state=IDLE; y, cout, err_flag, corr_cycles, out_valid all 0; in_ready=1 once released; internal regs cleared.
- Raw carries are combinational from inputs: rc[k] = carry-out of a[seg k]+b[seg k]+(k==0 ? cin : 0), for k=0..NSEG-1.
- IDLE: in_ready=1. On in_valid&&in_ready edge:
  - capture s=y_apx, rc, and rip=0;
  - err = |rc[NSEG-2:0];
  - if err: state=CORRECT, idx=1; else state=DONE, cout=rc[NSEG-1], corr_cycles=0.
- CORRECT, one edge per segment idx (1..NSEG-1):
  - ci = rc[idx-1] | rip;
  - {rip, s[idx]} = s[idx] + ci. At most one of rc/rip can be 1, since a segment with raw carry has low part ≤ 2^SEG-2, so ci is 1 bit.
  - After idx=NSEG-1: cout = rc[NSEG-1] | rip; corr_cycles=NSEG-1; state=DONE.
  - Otherwise idx++.
- DONE: out_valid=1, y=s, err_flag=err. Outputs hold stable while out_ready=0. On out_valid&&out_ready edge: state=IDLE, out_valid=0.
- Latency from the accept edge to out_valid high: 1 cycle with no error, NSEG cycles with error (4 at defaults).
- Throughput: one transaction in flight, no IDLE bypass; in_ready=0 in CORRECT and DONE.
- An rc[NSEG-1]-only carry is not an error; it is reported only on cout.
- y_apx is trusted, not cross-checked against a/b.
- Reset mid-CORRECT or mid-DONE discards the transaction and returns to IDLE.
- Inputs are ignored when in_ready=0.

Decomposition:
- Package eta_pkg: WIDTH/SEG defaults, NSEG derivation, state enum {IDLE, CORRECT, DONE}.
- Sub-module seg_carry_gen (combinational): a, b, cin -> rc[NSEG-1:0]. Reusable by the approximate-adder error monitors.

Test Plan:
- a=0x1234, b=0x4321, cin=0, y_apx=0x5555 -> y=0x5555, cout=0, err_flag=0, corr_cycles=0, out_valid 1 cycle after accept.
- a=0x000F, b=0x0001, y_apx=0x0000 -> y=0x0010, cout=0, err_flag=1, corr_cycles=3, out_valid 4 cycles after accept.
- a=0x0FFF, b=0x0001, y_apx=0x0FF0 (ripple through segs 1-2) -> y=0x1000, cout=0, err_flag=1.
- a=0xFFFF, b=0x0000, cin=1, y_apx=0xFFF0 -> y=0x0000, cout=1, err_flag=1; and a=0x8000, b=0x8000, y_apx=0x0000 -> y=0x0000, cout=1, err_flag=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> y/cout stable, in_ready=0; new in_valid ignored until the handshake completes.
- Deassert rst_n during CORRECT (idx=2) -> all outputs 0 immediately, in_ready=1 after release; next transaction correct.
